// File: rtl/mmio_axil_master.sv
// ============================================================================
// mmio_axil_master
// ----------------------------------------------------------------------------
// AXI4-Lite initiator. It issues one single-beat read or write at a time into
// the memory-mapped register file on behalf of on-chip sequencers. A caller
// presents a register ID (and write data) on the command port. The block maps
// the ID to BASE_ADDR + 4*ID, runs the AXI-Lite handshakes, and returns read
// data and the response code on the response port.
//
// Optional feature macro: MMIO_TIMEOUT_EN
//   defined   -> a watchdog aborts a transaction after TIMEOUT_CYCLES busy
//                cycles and reports DECERR (2'b11) with o_rsp_timeout = 1.
//   undefined -> no watchdog, o_rsp_timeout is always 0, and the block waits
//                indefinitely. TIMEOUT_CYCLES exists only in this build.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready       command handshake
//   i_cmd_we, i_cmd_id, i_cmd_wdata write enable, register ID, write data
//   o_rsp_valid / i_rsp_ready       response handshake
//   o_rsp_rdata, o_rsp_resp         read data (0 for writes), AXI resp code
//   o_rsp_timeout                   transaction aborted by the watchdog
//   o_m_aw*, o_m_w*, i_m_b*         AXI-Lite write address/data/response
//   o_m_ar*, i_m_r*                 AXI-Lite read address/data
// ============================================================================
module mmio_axil_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h9000_0000,
    parameter int          MEM_SIZE       = 256,
`ifdef MMIO_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 1023,
`endif
    localparam int         IDW            = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    // command port
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic           i_cmd_we,
    input  logic [IDW-1:0] i_cmd_id,
    input  logic [31:0]    i_cmd_wdata,
    // response port
    output logic           o_rsp_valid,
    input  logic           i_rsp_ready,
    output logic [31:0]    o_rsp_rdata,
    output logic [1:0]     o_rsp_resp,
    output logic           o_rsp_timeout,
    // AW channel
    output logic [31:0]    o_m_awaddr,
    output logic           o_m_awvalid,
    input  logic           i_m_awready,
    // W channel
    output logic [31:0]    o_m_wdata,
    output logic [3:0]     o_m_wstrb,
    output logic           o_m_wvalid,
    input  logic           i_m_wready,
    // B channel
    input  logic [1:0]     i_m_bresp,
    input  logic           i_m_bvalid,
    output logic           o_m_bready,
    // AR channel
    output logic [31:0]    o_m_araddr,
    output logic           o_m_arvalid,
    input  logic           i_m_arready,
    // R channel
    input  logic [31:0]    i_m_rdata,
    input  logic [1:0]     i_m_rresp,
    input  logic           i_m_rvalid,
    output logic           o_m_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // r_alive is 0 only while in reset and for the cycle before the first
    // edge after release; it keeps cmd_ready and the B/R ready lines low then.
    logic        r_alive;
    logic        r_awvalid, r_wvalid, r_arvalid;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_rsp_timeout;

    logic        w_awvalid_nxt, w_wvalid_nxt, w_arvalid_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic [1:0]  w_rsp_resp_nxt;
    logic        w_rsp_timeout_nxt;

    logic        w_cmd_hs;
    logic [31:0] w_cmd_addr;
    logic        w_aw_done, w_w_done;
    logic        w_tmo_hit;
    logic        w_do_abort;

    assign w_cmd_hs   = i_cmd_valid & o_cmd_ready;
    // 32-bit unsigned add: an address past 2^32 wraps around.
    assign w_cmd_addr = BASE_ADDR + (32'(i_cmd_id) << 2);
    // A write channel is done once its valid has dropped or it handshakes now.
    assign w_aw_done  = ~r_awvalid | i_m_awready;
    assign w_w_done   = ~r_wvalid  | i_m_wready;

`ifdef MMIO_TIMEOUT_EN
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_busy;

    assign w_busy    = (r_state == WR) | (r_state == WR_RESP) |
                       (r_state == RD_ADDR) | (r_state == RD_DATA);
    // r_cnt holds (busy cycles so far - 1), so equality with TMO_LAST marks
    // the TIMEOUT_CYCLES-th busy cycle.
    assign w_tmo_hit = w_busy & (r_cnt == TMO_LAST);

    // Watchdog counter: zero outside a bus transaction, +1 per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_busy) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= {CW{1'b0}};
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and next-output decode; completing handshakes take priority
    // over a watchdog abort in the same cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_arvalid_nxt     = r_arvalid;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_do_abort        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    w_addr_nxt  = w_cmd_addr;
                    w_wdata_nxt = i_cmd_wdata;
                    if (i_cmd_we) begin
                        w_state_nxt   = WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            WR: begin
                if (r_awvalid & i_m_awready) begin
                    w_awvalid_nxt = 1'b0;
                end else begin
                    w_awvalid_nxt = r_awvalid;
                end
                if (r_wvalid & i_m_wready) begin
                    w_wvalid_nxt = 1'b0;
                end else begin
                    w_wvalid_nxt = r_wvalid;
                end
                if (w_aw_done & w_w_done) begin
                    w_state_nxt = WR_RESP;
                end else if (w_tmo_hit) begin
                    w_do_abort = 1'b1;
                end else begin
                    w_state_nxt = WR;
                end
            end

            WR_RESP: begin
                if (i_m_bvalid) begin
                    w_state_nxt       = RSP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = 32'h0000_0000;
                    w_rsp_resp_nxt    = i_m_bresp;
                    w_rsp_timeout_nxt = 1'b0;
                end else if (w_tmo_hit) begin
                    w_do_abort = 1'b1;
                end else begin
                    w_state_nxt = WR_RESP;
                end
            end

            RD_ADDR: begin
                if (i_m_arready) begin
                    w_state_nxt   = RD_DATA;
                    w_arvalid_nxt = 1'b0;
                end else if (w_tmo_hit) begin
                    w_do_abort = 1'b1;
                end else begin
                    w_state_nxt = RD_ADDR;
                end
            end

            RD_DATA: begin
                if (i_m_rvalid) begin
                    w_state_nxt       = RSP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = i_m_rdata;
                    w_rsp_resp_nxt    = i_m_rresp;
                    w_rsp_timeout_nxt = 1'b0;
                end else if (w_tmo_hit) begin
                    w_do_abort = 1'b1;
                end else begin
                    w_state_nxt = RD_DATA;
                end
            end

            RSP: begin
                if (i_rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = RSP;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_awvalid_nxt   = 1'b0;
                w_wvalid_nxt    = 1'b0;
                w_arvalid_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase

        // Watchdog abort: withdraw every request and report DECERR.
        if (w_do_abort) begin
            w_state_nxt       = RSP;
            w_awvalid_nxt     = 1'b0;
            w_wvalid_nxt      = 1'b0;
            w_arvalid_nxt     = 1'b0;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_rdata_nxt   = 32'h0000_0000;
            w_rsp_resp_nxt    = 2'b11;
            w_rsp_timeout_nxt = 1'b1;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs and latched command; all forced to 0 by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive       <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_addr        <= 32'h0000_0000;
            r_wdata       <= 32'h0000_0000;
            r_wstrb       <= 4'h0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0000_0000;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_alive       <= 1'b1;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= 4'hF;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign o_cmd_ready   = r_alive & (r_state == IDLE);
    // B/R are always accepted so that stale beats from aborted transactions
    // drain; only WR_RESP/RD_DATA actually use them.
    assign o_m_bready    = r_alive;
    assign o_m_rready    = r_alive;
    assign o_m_awaddr    = r_addr;
    assign o_m_araddr    = r_addr;
    assign o_m_awvalid   = r_awvalid;
    assign o_m_wvalid    = r_wvalid;
    assign o_m_arvalid   = r_arvalid;
    assign o_m_wdata     = r_wdata;
    assign o_m_wstrb     = r_wstrb;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_mmio_axil_master.sv
// ============================================================================
// tb_mmio_axil_master
// Table of single transactions against a zero-wait slave, plus hand-written
// sequences for split write handshakes, response backpressure, stale B/R
// drain, watchdog / long stall, and reset in the middle of a read. Expected
// responses are queued when a command is driven and compared when the DUT
// completes the response handshake.
// ============================================================================
module tb_mmio_axil_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
    logic [7:0]  i_cmd_id;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid, i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_timeout;
    logic [31:0] o_m_awaddr;
    logic        o_m_awvalid, i_m_awready;
    logic [31:0] o_m_wdata;
    logic [3:0]  o_m_wstrb;
    logic        o_m_wvalid, i_m_wready;
    logic [1:0]  i_m_bresp;
    logic        i_m_bvalid, o_m_bready;
    logic [31:0] o_m_araddr;
    logic        o_m_arvalid, i_m_arready;
    logic [31:0] i_m_rdata;
    logic [1:0]  i_m_rresp;
    logic        i_m_rvalid, o_m_rready;

    always #5 clk = ~clk;

    mmio_axil_master #(
        .BASE_ADDR(32'h9000_0000),
        .MEM_SIZE (256)
`ifdef MMIO_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_id(i_cmd_id), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
        .o_m_awaddr(o_m_awaddr), .o_m_awvalid(o_m_awvalid), .i_m_awready(i_m_awready),
        .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb), .o_m_wvalid(o_m_wvalid), .i_m_wready(i_m_wready),
        .i_m_bresp(i_m_bresp), .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready),
        .o_m_araddr(o_m_araddr), .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready),
        .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready)
    );

    typedef struct {
        logic        we;
        logic [7:0]  id;
        logic [31:0] wdata;
        logic [31:0] sdata;   // slave read data
        logic [1:0]  resp;    // slave bresp/rresp
        logic [31:0] addr;    // expected bus address
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    vec_t vtmp;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp, input logic tmo);
        exp_t e;
        e.rdata = rdata;
        e.resp  = resp;
        e.tmo   = tmo;
        sb.push_back(e);
    endtask

    task automatic set_vec(input int i, input logic we, input logic [7:0] id, input logic [31:0] wdata,
                           input logic [31:0] sdata, input logic [1:0] resp, input logic [31:0] addr);
        vecs[i].we    = we;
        vecs[i].id    = id;
        vecs[i].wdata = wdata;
        vecs[i].sdata = sdata;
        vecs[i].resp  = resp;
        vecs[i].addr  = addr;
    endtask

    // Advance one clock and land 1 ns after the edge (drive and sample point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_rsp_valid && i_rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_spurious_rsp", 32'(o_rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_rdata", o_rsp_rdata, e.rdata);
                check("sb_resp", 32'(o_rsp_resp), 32'(e.resp));
                check("sb_timeout", 32'(o_rsp_timeout), 32'(e.tmo));
            end
        end
    end

    // One transaction with a zero-wait slave and exact cycle timing checks.
    task automatic run_zw(input vec_t v);
        // cycle 0: command accepted at the closing edge
        i_cmd_valid = 1'b1; i_cmd_we = v.we; i_cmd_id = v.id; i_cmd_wdata = v.wdata;
        i_m_awready = 1'b1; i_m_wready = 1'b1; i_m_arready = 1'b1; i_rsp_ready = 1'b1;
        check("zw_cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        push_exp(v.we ? 32'h0 : v.sdata, v.resp, 1'b0);
        tick();
        // cycle 1: address (and data) handshake
        i_cmd_valid = 1'b0;
        check("zw_cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
        if (v.we) begin
            check("zw_awvalid", 32'(o_m_awvalid), 32'd1);
            check("zw_wvalid", 32'(o_m_wvalid), 32'd1);
            check("zw_awaddr", o_m_awaddr, v.addr);
            check("zw_wdata", o_m_wdata, v.wdata);
            check("zw_wstrb", 32'(o_m_wstrb), 32'hF);
            check("zw_arvalid_wr", 32'(o_m_arvalid), 32'd0);
        end else begin
            check("zw_arvalid", 32'(o_m_arvalid), 32'd1);
            check("zw_araddr", o_m_araddr, v.addr);
            check("zw_awvalid_rd", 32'(o_m_awvalid), 32'd0);
        end
        tick();
        // cycle 2: B or R beat
        check("zw_valids_low", 32'({o_m_awvalid, o_m_wvalid, o_m_arvalid}), 32'd0);
        check("zw_rsp_early", 32'(o_rsp_valid), 32'd0);
        check("zw_b_r_ready", 32'({o_m_bready, o_m_rready}), 32'd3);
        if (v.we) begin
            i_m_bvalid = 1'b1; i_m_bresp = v.resp;
        end else begin
            i_m_rvalid = 1'b1; i_m_rdata = v.sdata; i_m_rresp = v.resp;
        end
        tick();
        // cycle 3: response presented
        i_m_bvalid = 1'b0; i_m_rvalid = 1'b0;
        check("zw_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("zw_rsp_resp", 32'(o_rsp_resp), 32'(v.resp));
        check("zw_rsp_rdata", o_rsp_rdata, v.we ? 32'h0 : v.sdata);
        tick();
        // cycle 4: handshake done, back to idle
        check("zw_rsp_done", 32'(o_rsp_valid), 32'd0);
        check("zw_cmd_ready_again", 32'(o_cmd_ready), 32'd1);
    endtask

    initial begin
        set_vec(0, 1'b1, 8'd20,  32'h0000_0100, 32'h0,          2'b00, 32'h9000_0050);
        set_vec(1, 1'b0, 8'd50,  32'h0,          32'h0001_0422, 2'b00, 32'h9000_00C8);
        set_vec(2, 1'b1, 8'd0,   32'hFFFF_FFFF, 32'h0,          2'b10, 32'h9000_0000);
        set_vec(3, 1'b0, 8'd255, 32'h0,          32'hDEAD_BEEF, 2'b11, 32'h9000_03FC);
        set_vec(4, 1'b1, 8'd255, 32'hA5A5_5A5A, 32'h0,          2'b01, 32'h9000_03FC);
        set_vec(5, 1'b0, 8'd1,   32'h0,          32'h0000_0000, 2'b01, 32'h9000_0004);

        i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_id = 8'd0; i_cmd_wdata = 32'h0;
        i_rsp_ready = 1'b0;
        i_m_awready = 1'b0; i_m_wready = 1'b0; i_m_arready = 1'b0;
        i_m_bresp = 2'b00; i_m_bvalid = 1'b0;
        i_m_rdata = 32'h0; i_m_rresp = 2'b00; i_m_rvalid = 1'b0;

        // ---- power-on reset ------------------------------------------------
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("rst_valids", 32'({o_m_awvalid, o_m_wvalid, o_m_arvalid, o_rsp_valid}), 32'd0);
        check("rst_readies", 32'({o_m_bready, o_m_rready}), 32'd0);
        check("rst_rsp_fields", 32'({o_rsp_resp, o_rsp_timeout}), 32'd0);
        tick(); tick();
        check("rst_cmd_ready_held", 32'(o_cmd_ready), 32'd0);
        rst_n = 1'b1;
        check("rel_cmd_ready_before_edge", 32'(o_cmd_ready), 32'd0);
        tick();
        check("rel_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("rel_readies", 32'({o_m_bready, o_m_rready}), 32'd3);

        // ---- table of zero-wait transactions --------------------------------
        for (int i = 0; i < 6; i++) begin
            run_zw(vecs[i]);
        end

        // ---- split write: W at cycle 1, AW at cycle 4, stale B in WR -------
        i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_id = 8'd33; i_cmd_wdata = 32'hCAFE_F00D;
        i_m_awready = 1'b0; i_m_wready = 1'b1; i_rsp_ready = 1'b1;
        push_exp(32'h0, 2'b00, 1'b0);
        tick();                                           // cycle 1
        i_cmd_valid = 1'b0;
        check("split_c1_valids", 32'({o_m_awvalid, o_m_wvalid}), 32'd3);
        check("split_c1_awaddr", o_m_awaddr, 32'h9000_0084);
        tick();                                           // cycle 2
        i_m_wready = 1'b0;
        i_m_bvalid = 1'b1; i_m_bresp = 2'b10;             // stale beat, must be dropped
        check("split_c2_wvalid", 32'(o_m_wvalid), 32'd0);
        check("split_c2_awvalid", 32'(o_m_awvalid), 32'd1);
        tick();                                           // cycle 3
        i_m_bvalid = 1'b0;
        check("split_c3_valids", 32'({o_m_awvalid, o_m_wvalid}), 32'd2);
        check("split_c3_no_rsp", 32'(o_rsp_valid), 32'd0);
        tick();                                           // cycle 4
        i_m_awready = 1'b1;
        check("split_c4_awvalid", 32'(o_m_awvalid), 32'd1);
        check("split_c4_awaddr", o_m_awaddr, 32'h9000_0084);
        tick();                                           // cycle 5
        i_m_awready = 1'b0;
        check("split_c5_awvalid", 32'(o_m_awvalid), 32'd0);
        check("split_c5_no_rsp", 32'(o_rsp_valid), 32'd0);
        i_m_bvalid = 1'b1; i_m_bresp = 2'b00;
        tick();                                           // cycle 6
        i_m_bvalid = 1'b0;
        check("split_c6_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("split_c6_rsp_resp", 32'(o_rsp_resp), 32'd0);
        tick();                                           // cycle 7
        check("split_single_rsp", 32'(o_rsp_valid), 32'd0);
        check("split_sb_empty", 32'(sb.size()), 32'd0);

        // ---- response backpressure on a SLVERR read ------------------------
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_id = 8'd7;
        i_m_arready = 1'b1; i_rsp_ready = 1'b0;
        push_exp(32'h1234_5678, 2'b10, 1'b0);
        tick();                                           // cycle 1
        i_cmd_valid = 1'b0;
        check("bp_araddr", o_m_araddr, 32'h9000_001C);
        tick();                                           // cycle 2
        i_m_rvalid = 1'b1; i_m_rdata = 32'h1234_5678; i_m_rresp = 2'b10;
        tick();                                           // cycle 3
        i_m_rvalid = 1'b0; i_m_rdata = 32'hBAD0_BAD0; i_m_rresp = 2'b00;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("bp_rsp_resp", 32'(o_rsp_resp), 32'd2);
            check("bp_rsp_rdata", o_rsp_rdata, 32'h1234_5678);
            check("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
            tick();
        end
        i_rsp_ready = 1'b1;
        check("bp_rsp_still_valid", 32'(o_rsp_valid), 32'd1);
        tick();
        check("bp_rsp_done", 32'(o_rsp_valid), 32'd0);
        check("bp_cmd_ready_after", 32'(o_cmd_ready), 32'd1);

        // ---- stale B/R beats while idle are drained -------------------------
        i_m_bvalid = 1'b1; i_m_bresp = 2'b11;
        i_m_rvalid = 1'b1; i_m_rdata = 32'h5555_AAAA;
        tick();
        i_m_bvalid = 1'b0; i_m_rvalid = 1'b0;
        check("drain_no_rsp", 32'(o_rsp_valid), 32'd0);
        check("drain_cmd_ready", 32'(o_cmd_ready), 32'd1);
        run_zw(vecs[1]);

`ifdef MMIO_TIMEOUT_EN
        // ---- watchdog: AW never accepted, abort after 16 busy cycles -------
        i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_id = 8'd2; i_cmd_wdata = 32'h55;
        i_m_awready = 1'b0; i_m_wready = 1'b1; i_rsp_ready = 1'b1;
        push_exp(32'h0, 2'b11, 1'b1);
        tick();                                           // cycle 1
        i_cmd_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) i_m_wready = 1'b0;
            check("wd_no_rsp_yet", 32'(o_rsp_valid), 32'd0);
            check("wd_awvalid_held", 32'(o_m_awvalid), 32'd1);
            tick();
        end
        // cycle 17
        check("wd_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("wd_rsp_resp", 32'(o_rsp_resp), 32'd3);
        check("wd_rsp_timeout", 32'(o_rsp_timeout), 32'd1);
        check("wd_rsp_rdata", o_rsp_rdata, 32'h0);
        check("wd_valids_dropped", 32'({o_m_awvalid, o_m_wvalid}), 32'd0);
        tick();
        check("wd_idle", 32'(o_cmd_ready), 32'd1);
        i_m_bvalid = 1'b1; i_m_bresp = 2'b00;             // late B for the aborted write
        tick();
        i_m_bvalid = 1'b0;
        check("wd_late_b_swallowed", 32'(o_rsp_valid), 32'd0);
        tick();
        check("wd_late_b_quiet", 32'(o_rsp_valid), 32'd0);
        run_zw(vecs[3]);
`else
        // ---- no watchdog: a 40-cycle AW stall still completes normally ------
        i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_id = 8'd2; i_cmd_wdata = 32'h55;
        i_m_awready = 1'b0; i_m_wready = 1'b1; i_rsp_ready = 1'b1;
        push_exp(32'h0, 2'b00, 1'b0);
        tick();                                           // cycle 1
        i_cmd_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) i_m_wready = 1'b0;
            if (c == 1 || c == 20 || c == 40) begin
                check("stall_no_rsp", 32'(o_rsp_valid), 32'd0);
                check("stall_awvalid_held", 32'(o_m_awvalid), 32'd1);
            end
            tick();
        end
        i_m_awready = 1'b1;                               // cycle 41
        tick();
        i_m_awready = 1'b0;                               // cycle 42
        i_m_bvalid = 1'b1; i_m_bresp = 2'b00;
        tick();
        i_m_bvalid = 1'b0;                                // cycle 43
        check("stall_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("stall_no_timeout", 32'(o_rsp_timeout), 32'd0);
        tick();
        check("stall_done", 32'(o_rsp_valid), 32'd0);
`endif

        // ---- reset while in RD_DATA -----------------------------------------
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_id = 8'd9;
        i_m_arready = 1'b1; i_rsp_ready = 1'b1;
        tick();                                           // cycle 1
        i_cmd_valid = 1'b0;
        check("mid_arvalid", 32'(o_m_arvalid), 32'd1);
        tick();                                           // cycle 2: RD_DATA
        check("mid_in_rd_data", 32'({o_m_arvalid, o_cmd_ready, o_rsp_valid}), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("mid_rst_readies", 32'({o_m_bready, o_m_rready}), 32'd0);
        check("mid_rst_araddr", o_m_araddr, 32'h0);
        check("mid_rst_wdata", o_m_wdata, 32'h0);
        check("mid_rst_wstrb", 32'(o_m_wstrb), 32'd0);
        check("mid_rst_rsp", 32'({o_rsp_valid, o_rsp_resp, o_rsp_timeout}), 32'd0);
        i_m_rvalid = 1'b1; i_m_rdata = 32'h7777_7777;   // R beat of the killed read
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("mid_rel_no_rsp", 32'(o_rsp_valid), 32'd0);
        i_m_rvalid = 1'b0;
        tick();
        check("mid_rel_no_rsp2", 32'(o_rsp_valid), 32'd0);
        run_zw(vecs[0]);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_axil_master.md
# mmio_axil_master

AXI4-Lite initiator that issues single-beat reads and writes into the PS-facing memory-mapped register file from the RTL side. It serves on-chip sequencers and the self-test controller. Callers present a register ID and data on a valid/ready command port. The block converts the ID to a byte address, runs the AXI-Lite handshakes, and returns data and response code on a valid/ready response port. An optional watchdog aborts transactions the slave never completes.

## Interface
- `BASE_ADDR`, default 32'h9000_0000: byte address of register ID 0.
- `MEM_SIZE`, default 256: number of mapped 32-bit registers. ID width is `IDW = $clog2(MEM_SIZE)`.
- `TIMEOUT_CYCLES`, default 1023: watchdog limit in clk cycles. Used only when `MMIO_TIMEOUT_EN` is defined.
- `clk` in 1: single clock for everything.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1; `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_id` in IDW: register ID.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: AXI response code (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11).
- `rsp_timeout` out 1: transaction was aborted by the watchdog.
- AW channel: `m_awaddr` out 32, `m_awvalid` out 1, `m_awready` in 1.
- W channel: `m_wdata` out 32, `m_wstrb` out 4, `m_wvalid` out 1, `m_wready` in 1.
- B channel: `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1.
- AR channel: `m_araddr` out 32, `m_arvalid` out 1, `m_arready` in 1.
- R channel: `m_rdata` in 32, `m_rresp` in 2, `m_rvalid` in 1, `m_rready` out 1.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- `cmd_ready` = (state == IDLE).
- IDLE, on command handshake:
  - Latch the command.
  - Address = `BASE_ADDR + (cmd_id << 2)`, computed in 32-bit unsigned arithmetic; overflow wraps.
  - Go to WR if `cmd_we`, else RD_ADDR.
- WR:
  - `m_awvalid` and `m_wvalid` are registered high on entry.
  - Each drops independently the cycle after its own handshake.
  - Either ordering of `m_awready`/`m_wready` is legal, including the same cycle.
  - Go to WR_RESP once both handshakes have completed.
  - `m_wstrb` = 4'hF.
- WR_RESP: on `m_bvalid`, capture `m_bresp` into `rsp_resp`, set `rsp_rdata` = 0, go to RSP.
- RD_ADDR: `m_arvalid` is high until `m_arready`, then go to RD_DATA.
- RD_DATA: on `m_rvalid`, capture `m_rdata` and `m_rresp`, go to RSP.
- RSP:
  - `rsp_valid` = 1 and all `rsp_*` outputs hold stable until `rsp_ready`.
  - Go to IDLE on the response handshake.
- `m_bready` and `m_rready` are 1 in every state after reset.
  - B/R beats arriving outside WR_RESP/RD_DATA are discarded.
  - This drains stale responses left by aborted transactions.
- Reset: all outputs go to 0 immediately (asynchronous), including `cmd_ready`, every `m_*valid`, `m_bready`/`m_rready`, and all `rsp_*`. State returns to IDLE and the latched command is lost. `cmd_ready` rises the first clk edge after `rst_n` deasserts.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state.
- Write with zero-wait slave (accept at cycle 0):
  - cycle 1: AW and W valid and handshake.
  - cycle 2: B handshake.
  - cycle 3: `rsp_valid`.
- Read with zero-wait slave:
  - cycle 1: AR handshake.
  - cycle 2: R handshake.
  - cycle 3: `rsp_valid`.
- Earliest next command accept is the cycle after the response handshake.
- Only one transaction is outstanding at a time; there is no pipelining.

## Configuration
- `MMIO_TIMEOUT_EN` defined:
  - A counter clears on leaving IDLE and increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - If the count reaches `TIMEOUT_CYCLES` with no completing handshake that cycle:
    - Drop all `m_*valid`.
    - Set `rsp_resp` = 2'b11, `rsp_timeout` = 1, `rsp_rdata` = 0.
    - Go to RSP.
  - A completing handshake on the limit cycle wins over the abort.
- `MMIO_TIMEOUT_EN` undefined: there is no counter, `rsp_timeout` is tied to 0, and the block waits indefinitely.

## Test plan
- Write: `cmd_id`=20, `cmd_wdata`=0x100, slave zero-wait, `m_bresp`=00 -> `m_awaddr`=0x9000_0050, `m_wdata`=0x100, `m_wstrb`=F, `rsp_valid` at cycle 3 with `rsp_resp`=00.
- Read: `cmd_id`=50, slave returns `m_rdata`=0x0001_0422 with `m_rresp`=00 -> `m_araddr`=0x9000_00C8, `rsp_rdata`=0x0001_0422, `rsp_resp`=00.
- Split write handshakes: `m_wready` at cycle 1, `m_awready` at cycle 4 -> `m_wvalid` low from cycle 2, `m_awvalid` held through cycle 4, a single response, and `m_awaddr` stable throughout.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles after a read returning `m_rresp`=10 -> `rsp_*` stable at `rsp_resp`=10, `cmd_ready`=0 until the response handshake.
- Watchdog (`MMIO_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, `m_awready` never asserted) -> abort at 16 cycles, `rsp_resp`=11, `rsp_timeout`=1. A late `m_bvalid` is swallowed, and the next read completes normally.
- Reset mid-op: assert `rst_n`=0 while in RD_DATA -> all outputs 0 in the same cycle. After release, `cmd_ready`=1 and no spurious `rsp_valid` appears.
